sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Single-clock, parametrised FIFO: the synchronous successor to the team's dual-clock FIFO, for buffering within one clock domain. Adds over the dual-clock block:
- a selectable read mode (registered or first-word-fall-through);
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- overflow and underflow error pulses.

It sits between a producer and a consumer in the same clock domain. Sizes are set per instance.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of storage words; power of two, ≥2; AW = log2(DEPTH)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  WIDTH  write word
- rd_en  in  1  read request
- rd_data  out  WIDTH  read word
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- data_cnt  out  AW+1  words currently stored (0..DEPTH)
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage is a DEPTH×WIDTH array with AW-bit wr_ptr and rd_ptr. Pointers wrap DEPTH-1 → 0. The array is not reset.
- Write acceptance (wa): wa = wr_en && !fifo_full. On wa, mem[wr_ptr] ← wr_data and wr_ptr increments.
- Read acceptance (ra): ra = rd_en && !fifo_empty. On ra, rd_ptr increments.
- Acceptance is evaluated on the pre-edge flags only.
  - When full, a write is rejected even if a read is accepted the same cycle.
  - When empty, a read is rejected even if a write is accepted the same cycle.
- data_cnt update per edge:
  - +1 on wa only
  - −1 on ra only
  - unchanged on both or neither
- All flags are registered and derived from the next count, so they are always consistent with data_cnt in the same cycle.
- Error pulses:
  - overflow = 1 for exactly one cycle after any edge with wr_en && fifo_full.
  - underflow = 1 for exactly one cycle after any edge with rd_en && fifo_empty.
  - Rejected requests change no other state.
- FWFT = 0 (registered read):
  - On ra, rd_data ← mem[rd_ptr] at that edge.
  - Otherwise rd_data holds its last value.
- FWFT = 1 (fall-through):
  - rd_data = mem[rd_ptr] combinationally.
  - It is valid whenever fifo_empty = 0. rd_en acknowledges (pops) the displayed word.
  - Value is undefined while empty.
- Reset (any cycle, including mid-transfer):
  - Pointers, count and all flags clear; stored words are discarded.
  - Requests in the reset cycle are ignored and raise no error pulse.

## Timing
- Reset values: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, data_cnt=0, overflow=0, underflow=0; rd_data=0 when FWFT=0.
- Write-to-visibility: a word accepted at edge N drives fifo_empty=0 and data_cnt from edge N onward.
  - FWFT=1: rd_data shows the word after edge N.
  - FWFT=0: the word needs a read accepted at edge ≥ N+1; rd_data is valid after that edge (1-cycle read latency).
- Full: fifo_full rises at the edge accepting the DEPTH-th word and falls at the first edge with ra only.
- Empty: fifo_empty rises at the edge of the last ra without a wa, and falls at the first edge with wa only.
- Throughput: one write and one read per cycle sustained at any count 1..DEPTH-1.
- No combinational path from wr_en/rd_en to any output. In FWFT=1, rd_data depends on rd_ptr only.

## Test plan
All scenarios use WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1, checked in both FWFT modes unless stated.

1. Reset, then 8 writes 0x01..0x08 on consecutive cycles:
   - data_cnt steps 1..8; almost_empty falls at count 2; almost_full rises at count 6; fifo_full rises at count 8.
   - No overflow pulse.
2. From full, 9th write of 0x55:
   - overflow=1 for one cycle; data_cnt stays 8.
   - Subsequent 8 reads return 0x01..0x08 in order. In FWFT=0 each value appears the cycle after its rd_en.
   - fifo_empty=1 after the 8th read.
3. Empty, rd_en=1 for 2 cycles:
   - underflow pulses twice; data_cnt=0; rd_data unchanged (FWFT=0).
4. Wrap-around: 16 writes interleaved with 16 reads, occupancy held at 3:
   - Read sequence equals write sequence; pointers wrap twice.
   - fifo_full never asserts; data_cnt stays 3.
5. Simultaneous edge cases:
   - At count 8, wr_en=rd_en=1: read accepted, write rejected, overflow pulse, count 7.
   - At count 0, both high: write accepted, underflow pulse, count 1.
   - At count 4, both high: count stays 4.
6. Reset mid-operation at count 5 with wr_en=1:
   - Next cycle: data_cnt=0, fifo_empty=1, almost_empty=1, no overflow/underflow.
   - Next write 0xA5 is the first word read out.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered or fall-through read, level flags and error pulses.
// Latency: write visible in flags/count after 1 edge; FWFT=0 read data 1 cycle after accepted rd_en, FWFT=1 data shown combinationally from storage.
// Backpressure: writes are dropped while fifo_full (overflow pulse), reads are dropped while fifo_empty (underflow pulse).
//
// Ports:
//   clk, rst                 sole clock; synchronous active-high reset
//   wr_en, wr_data           write request and word
//   rd_en, rd_data           read request (pop) and read word
//   fifo_full, fifo_empty    count == DEPTH / count == 0
//   almost_full/_empty       count >= AF_LEVEL / count <= AE_LEVEL
//   data_cnt                 words stored, 0..DEPTH
//   overflow, underflow      one-cycle pulses after a rejected write / read
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     data_cnt,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    // Storage array; deliberately not reset, contents are only meaningful
    // between rd_ptr and wr_ptr.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          afull_q,  afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q,    ovf_d;
    logic          unf_q,    unf_d;

    logic wa;
    logic ra;

    // Acceptance looks only at the registered flags, so a read in the same
    // cycle never frees room for a write at full, and a write never supplies
    // data for a read at empty. This also keeps wr_en/rd_en off every
    // combinational output path.
    always_comb begin
        wa       = wr_en && !full_q;
        ra       = rd_en && !empty_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (wa) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (ra) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({wa, ra})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        // Flags come from the next count so they line up with data_cnt.
        full_d   = (cnt_d == CNT_FULL);
        empty_d  = (cnt_d == '0);
        afull_d  = (cnt_d >= CNT_AF);
        aempty_d = (cnt_d <= CNT_AE);

        ovf_d    = wr_en && full_q;
        unf_d    = rd_en && empty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Writes during reset are ignored so the post-reset state is clean.
    always_ff @(posedge clk) begin
        if (!rst && wa) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always on the output; only the pointer selects it.
            assign rd_data = mem_q[rd_ptr_q];
        end else begin : g_reg_read
            logic [WIDTH-1:0] rd_data_q, rd_data_d;

            always_comb begin
                rd_data_d = rd_data_q;
                if (ra) begin
                    rd_data_d = mem_q[rd_ptr_q];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end

            assign rd_data = rd_data_q;
        end
    endgenerate

    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign data_cnt     = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: two instances (registered and fall-through read) share stimulus.
// Stimulus pushes expected count/pulses and read words into queues; a negedge monitor pops and compares.
// Both instances use WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
module tb_sync_fifo_param;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic       rd_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] rd_data0, rd_data1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst;
        logic ra;
        logic ovf;
        logic unf;
        int   cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rd0_q[$];   // expected registered-read words, in pop order
    logic [7:0] fw_q[$];    // expected fall-through head sequence
    logic [7:0] mq[$];      // model storage used at issue time
    int         mcnt    = 0;
    logic [7:0] last_rd0 = 8'h00;
    bit         due     = 1'b0;
    exp_t       cur;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data0), .fifo_full(full0), .fifo_empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .data_cnt(cnt0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data1), .fifo_full(full1), .fifo_empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .data_cnt(cnt1),
        .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_inst(input string tag, input logic [3:0] c, input logic f, input logic e,
                            input logic af, input logic ae, input logic ov, input logic un,
                            input exp_t x);
        chk({tag, " data_cnt"},     int'(c),  x.cnt);
        chk({tag, " fifo_full"},    int'(f),  int'(x.cnt == 8));
        chk({tag, " fifo_empty"},   int'(e),  int'(x.cnt == 0));
        chk({tag, " almost_full"},  int'(af), int'(x.cnt >= 6));
        chk({tag, " almost_empty"}, int'(ae), int'(x.cnt <= 1));
        chk({tag, " overflow"},     int'(ov), int'(x.ovf));
        chk({tag, " underflow"},    int'(un), int'(x.unf));
    endtask

    // Monitor: at each negedge, check the state produced by the previous edge,
    // then check the fall-through head for the request about to be applied.
    always @(negedge clk) begin
        if (due) begin
            cur = exp_q.pop_front();
            chk_inst("fwft0", cnt0, full0, empty0, af0, ae0, ovf0, unf0, cur);
            chk_inst("fwft1", cnt1, full1, empty1, af1, ae1, ovf1, unf1, cur);
            if (cur.rst) begin
                last_rd0 = 8'h00;
            end else if (cur.ra) begin
                if (rd0_q.size() == 0) begin
                    chk("fwft0 rd_q underrun", 1, 0);
                end else begin
                    last_rd0 = rd0_q.pop_front();
                end
            end
            chk("fwft0 rd_data", int'(rd_data0), int'(last_rd0));
        end
        due = (exp_q.size() > 0);

        if (!rst && !empty1) begin
            if (fw_q.size() == 0) begin
                chk("fwft1 head underrun", 1, 0);
            end else begin
                chk("fwft1 rd_data", int'(rd_data1), int'(fw_q[0]));
                if (rd_en) begin
                    void'(fw_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; the model decides acceptance from pre-edge count.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rs);
        exp_t e;
        logic wa, ra;
        @(posedge clk);
        #1;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        rst     = rs;
        e.rst = rs;
        if (rs) begin
            mq.delete();
            fw_q.delete();
            mcnt  = 0;
            e.ra  = 1'b0;
            e.ovf = 1'b0;
            e.unf = 1'b0;
        end else begin
            wa    = w && (mcnt < 8);
            ra    = r && (mcnt > 0);
            e.ra  = ra;
            e.ovf = w && (mcnt == 8);
            e.unf = r && (mcnt == 0);
            if (ra) rd0_q.push_back(mq.pop_front());
            if (wa) begin
                mq.push_back(d);
                fw_q.push_back(d);
            end
            if (wa && !ra) mcnt++;
            if (ra && !wa) mcnt--;
        end
        e.cnt = mcnt;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [7:0] d); step(1'b1, d, 1'b0, 1'b0); endtask
    task automatic rd();                    step(1'b0, 8'h00, 1'b1, 1'b0); endtask
    task automatic idle();                  step(1'b0, 8'h00, 1'b0, 1'b0); endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle();

        // 1: fill with 0x01..0x08
        for (int i = 1; i <= 8; i++) wr(8'(i));
        // 2: overflow at full, then drain in order
        wr(8'h55);
        idle();
        for (int i = 0; i < 8; i++) rd();
        idle();
        // 3: underflow twice; registered read data must hold 0x08
        rd();
        rd();
        idle();

        // 4: hold occupancy at 3 while streaming 16 words through
        wr(8'h10); wr(8'h11); wr(8'h12);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h13 + i), 1'b1, 1'b0);
        rd(); rd(); rd();
        idle();

        // 5: simultaneous requests at full, empty and mid-level
        for (int i = 0; i < 8; i++) wr(8'(8'h40 + i));
        step(1'b1, 8'h99, 1'b1, 1'b0);          // count 8 -> 7, overflow
        for (int i = 0; i < 7; i++) rd();       // down to 0
        step(1'b1, 8'h60, 1'b1, 1'b0);          // count 0 -> 1, underflow
        wr(8'h61); wr(8'h62); wr(8'h63);        // count 4
        step(1'b1, 8'h64, 1'b1, 1'b0);          // stays 4
        for (int i = 0; i < 4; i++) rd();
        idle();

        // 6: reset mid-operation with a write pending
        for (int i = 0; i < 5; i++) wr(8'(8'h80 + i));
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        idle();
        wr(8'hA5);
        idle();
        rd();
        idle();
        idle();

        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rd_q drained", rd0_q.size(), 0);
        chk("exp_q drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
